intersection_select: RTL and testbench

Trilateration back end: takes the two candidate points from the circle-intersection stage (anchors B, C) plus the third anchor A and its range, and picks the candidate whose squared distance to A best matches rA². A single shared multiplier is time-multiplexed through a small FSM. Valid/ready handshakes on both sides. The output is the final located point.

---
 rtl/intersection_select.sv | 135 +++++++++++++
 tb/tb_intersection_select.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/intersection_select.sv
// intersection_select: picks the circle-intersection candidate whose squared
// distance to anchor A best matches rA^2, using one time-shared squarer.
module intersection_select #(
   parameter int N = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [N-1:0]   xA,
   input  logic signed [N-1:0]   yA,
   input  logic        [N:0]     rA,
   input  logic signed [4*N+9:0] x1,
   input  logic signed [4*N+9:0] x2,
   input  logic signed [3*N+6:0] y1,
   input  logic signed [3*N+6:0] y2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [4*N+9:0] x_out,
   output logic signed [3*N+6:0] y_out,
   output logic                  sel,
   output logic [8*N+22:0]       err
);
   localparam int XW = 4*N+10;
   localparam int YW = 3*N+7;
   localparam int DX = XW+1;
   localparam int DY = YW+1;
   localparam int AW = 8*N+23;

   typedef enum logic [2:0] {IDLE, SQ_X1, SQ_Y1, SQ_X2, SQ_Y2, SQ_R, CMP, OUT} state_t;

   state_t state_q, state_d;
   logic signed [N-1:0]  xa_q, ya_q;
   logic        [N:0]    ra_q;
   logic signed [XW-1:0] x1_q, x2_q;
   logic signed [YW-1:0] y1_q, y2_q;
   logic [AW-1:0]        acc1_q, acc1_d, acc2_q, acc2_d, r2_q, r2_d;
   logic signed [DX-1:0] dx1, dx2, op;
   logic signed [DY-1:0] dy1, dy2;
   logic signed [2*DX-1:0] sq;
   logic [AW-1:0]        sq_u, e1, e2;
   logic                 sel_c;

   assign dx1 = {x1_q[XW-1], x1_q} - {{(DX-N){xa_q[N-1]}}, xa_q};
   assign dx2 = {x2_q[XW-1], x2_q} - {{(DX-N){xa_q[N-1]}}, xa_q};
   assign dy1 = {y1_q[YW-1], y1_q} - {{(DY-N){ya_q[N-1]}}, ya_q};
   assign dy2 = {y2_q[YW-1], y2_q} - {{(DY-N){ya_q[N-1]}}, ya_q};
   // A square is never negative, so the extra top bit is always zero.
   assign sq    = op * op;
   assign sq_u  = {1'b0, sq};
   assign e1    = (acc1_q >= r2_q) ? acc1_q - r2_q : r2_q - acc1_q;
   assign e2    = (acc2_q >= r2_q) ? acc2_q - r2_q : r2_q - acc2_q;
   assign sel_c = e2 < e1;

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == OUT;

   always_comb begin
      state_d = state_q;
      acc1_d  = acc1_q;
      acc2_d  = acc2_q;
      r2_d    = r2_q;
      op      = '0;
      case (state_q)
         IDLE:  state_d = in_valid ? SQ_X1 : IDLE;
         SQ_X1: begin
            op      = dx1;
            acc1_d  = sq_u;
            state_d = SQ_Y1;
         end
         SQ_Y1: begin
            op      = {{(DX-DY){dy1[DY-1]}}, dy1};
            acc1_d  = acc1_q + sq_u;
            state_d = SQ_X2;
         end
         SQ_X2: begin
            op      = dx2;
            acc2_d  = sq_u;
            state_d = SQ_Y2;
         end
         SQ_Y2: begin
            op      = {{(DX-DY){dy2[DY-1]}}, dy2};
            acc2_d  = acc2_q + sq_u;
            state_d = SQ_R;
         end
         SQ_R: begin
            op      = {{(DX-N-1){1'b0}}, ra_q};
            r2_d    = sq_u;
            state_d = CMP;
         end
         CMP:   state_d = OUT;
         OUT:   state_d = out_ready ? IDLE : OUT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc1_q  <= '0;
         acc2_q  <= '0;
         r2_q    <= '0;
         xa_q    <= '0;
         ya_q    <= '0;
         ra_q    <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         y1_q    <= '0;
         y2_q    <= '0;
         x_out   <= '0;
         y_out   <= '0;
         sel     <= 1'b0;
         err     <= '0;
      end else begin
         state_q <= state_d;
         acc1_q  <= acc1_d;
         acc2_q  <= acc2_d;
         r2_q    <= r2_d;
         if (state_q == IDLE && in_valid) begin
            xa_q <= xA;
            ya_q <= yA;
            ra_q <= rA;
            x1_q <= x1;
            x2_q <= x2;
            y1_q <= y1;
            y2_q <= y2;
         end
         if (state_q == CMP) begin
            x_out <= sel_c ? x2_q : x1_q;
            y_out <= sel_c ? y2_q : y1_q;
            sel   <= sel_c;
            err   <= sel_c ? e2 : e1;
         end
      end
   end
endmodule

// File: tb/tb_intersection_select.sv
// tb_intersection_select: directed vectors with hand-computed results for
// candidate selection, latency, backpressure and mid-operation reset.
module tb_intersection_select;
   localparam int N = 8;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic signed [N-1:0]   xA, yA;
   logic        [N:0]     rA;
   logic signed [4*N+9:0] x1, x2;
   logic signed [3*N+6:0] y1, y2;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic signed [4*N+9:0] x_out;
   logic signed [3*N+6:0] y_out;
   logic                  sel;
   logic [8*N+22:0]       err;

   int n_chk = 0;
   int n_fail = 0;

   intersection_select #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .xA(xA), .yA(yA), .rA(rA), .x1(x1), .x2(x2), .y1(y1), .y2(y2),
      .out_valid(out_valid), .out_ready(out_ready),
      .x_out(x_out), .y_out(y_out), .sel(sel), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic signed [7:0] xa, input logic signed [7:0] ya, input logic [8:0] ra,
                        input logic signed [41:0] a1, input logic signed [30:0] b1,
                        input logic signed [41:0] a2, input logic signed [30:0] b2);
      xA = xa; yA = ya; rA = ra; x1 = a1; y1 = b1; x2 = a2; y2 = b2;
   endtask

   task automatic send(input string tag);
      int t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      check({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input int exp_lat);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
   endtask

   task automatic expect_res(input string tag, input logic s, input logic signed [41:0] x,
                             input logic signed [30:0] y, input logic [86:0] e);
      check({tag, "_sel"}, sel, s);
      check({tag, "_x"}, x_out, x);
      check({tag, "_y"}, y_out, y);
      check({tag, "_err"}, err, e);
   endtask

   task automatic xfer(input string tag);
      @(posedge clk); #1;
      check({tag, "_ov_drop"}, out_valid, 0);
      check({tag, "_ir_rise"}, in_ready, 1);
   endtask

   task automatic run(input string tag, input logic s, input logic signed [41:0] x,
                      input logic signed [30:0] y, input logic [86:0] e);
      send(tag);
      wait_out(tag, 6);
      expect_res(tag, s, x, y, e);
      xfer(tag);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      #3;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      expect_res("rst", 0, 0, 0, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      drive(0, 0, 5, 3, 4, 6, 8);
      run("first", 0, 3, 4, 0);
      drive(0, 0, 5, 6, 8, 3, 4);
      run("second", 1, 3, 4, 0);
      drive(0, 0, 5, 1, 1, 5, 1);
      run("near", 1, 5, 1, 1);
      check("hold_x_idle", x_out, 5);
      drive(0, 0, 5, 5, 0, 0, -5);
      run("tie", 0, 5, 0, 0);
      drive(-32, 108, 10, -32, 118, -32, -111);
      run("neg", 0, -32, 118, 0);
      drive(127, 127, 511, -(42'sd1 <<< 41), -(31'sd1 <<< 30), 0, 0);
      run("extreme", 1, 0, 0, 228863);

      // Backpressure: the next bundle waits on in_valid until the transfer.
      drive(0, 0, 5, 3, 4, 6, 8);
      out_ready = 1'b0;
      send("bp");
      wait_out("bp", 6);
      drive(0, 0, 5, 1, 1, 5, 1);
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_ov", out_valid, 1);
         check("bp_ir", in_ready, 0);
         expect_res("bp_hold", 0, 3, 4, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_xfer_ov", out_valid, 0);
      check("bp_xfer_ir", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_next_accept", in_ready, 0);
      wait_out("bp_next", 6);
      expect_res("bp_next", 1, 5, 1, 1);
      xfer("bp_next");

      // Leave nonzero outputs, then reset during SQ_Y2 of the next bundle.
      drive(0, 0, 5, 3, 4, 6, 8);
      out_ready = 1'b0;
      send("pre");
      wait_out("pre", 6);
      out_ready = 1'b1;
      xfer("pre");
      drive(-32, 108, 10, -32, 118, -32, -111);
      send("mid");
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ov", out_valid, 0);
      check("mid_rst_ir", in_ready, 1);
      expect_res("mid_rst", 0, 0, 0, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ir", in_ready, 1);
      drive(0, 0, 5, 6, 8, 3, 4);
      run("post_rst", 1, 3, 4, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
